// File: rtl/neuron_layer_sequencer_pkg.sv
// neuron_pkg: layer constants, sequencer states and the signed 8.18 neuron output type
package neuron_pkg;
  localparam int NUM_NEURONS = 10;
  localparam int OUTPUT_WIDTH = 26;
  localparam int CLASS_WIDTH = 4;
  typedef enum logic [2:0] {IDLE, RELEASE, RUN, SCAN, DONE} state_t;
  typedef logic signed [OUTPUT_WIDTH-1:0] out_t;
endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// neuron_layer_sequencer_if: start, neuron bank (out/done/rst) and result bundle; slave = sequencer, master = loader and neurons
interface neuron_layer_sequencer_if #(
  parameter int NUM_NEURONS = neuron_pkg::NUM_NEURONS,
  parameter int OUTPUT_WIDTH = neuron_pkg::OUTPUT_WIDTH,
  parameter int CLASS_WIDTH = neuron_pkg::CLASS_WIDTH
);
  logic start;
  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] neuron_out;
  logic [NUM_NEURONS-1:0] neuron_done;
  logic neuron_rst;
  logic busy;
  logic result_valid;
  logic [CLASS_WIDTH-1:0] result_class;
  logic signed [OUTPUT_WIDTH-1:0] result_score;
  logic timeout;
  modport master (
    output start, neuron_out, neuron_done,
    input neuron_rst, busy, result_valid, result_class, result_score, timeout
  );
  modport slave (
    input start, neuron_out, neuron_done,
    output neuron_rst, busy, result_valid, result_class, result_score, timeout
  );
endinterface

// File: rtl/neuron_layer_sequencer_argmax_scan.sv
// argmax_scan: load seeds best with neuron 0, each step compares neuron k (signed, strict >) and advances k; win_* is best including the current step
module argmax_scan #(
  parameter int NUM_NEURONS = neuron_pkg::NUM_NEURONS,
  parameter int OUTPUT_WIDTH = neuron_pkg::OUTPUT_WIDTH,
  parameter int CLASS_WIDTH = neuron_pkg::CLASS_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic step,
  input logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] vals,
  output logic last,
  output logic [CLASS_WIDTH-1:0] win_idx,
  output logic signed [OUTPUT_WIDTH-1:0] win_score
);
  logic signed [OUTPUT_WIDTH-1:0] lane [NUM_NEURONS];
  logic signed [OUTPUT_WIDTH-1:0] cur, best_score;
  logic [CLASS_WIDTH-1:0] k, best_idx;
  logic gt;
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    assign lane[i] = vals[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end
  always_comb begin
    cur = lane[k];
    gt = step && (cur > best_score);
    win_idx = gt ? k : best_idx;
    win_score = gt ? cur : best_score;
    last = k == CLASS_WIDTH'(NUM_NEURONS - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      best_idx <= '0;
      best_score <= '0;
    end else if (load) begin
      k <= CLASS_WIDTH'(1);
      best_idx <= '0;
      best_score <= lane[0];
    end else if (step) begin
      k <= k + 1'b1;
      best_idx <= win_idx;
      best_score <= win_score;
    end
  end
endmodule

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: releases the neuron bank on start, waits for all done or timeout, scans for argmax; ports clk, rst, bus (slave)
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS = neuron_pkg::NUM_NEURONS,
  parameter int OUTPUT_WIDTH = neuron_pkg::OUTPUT_WIDTH,
  parameter int CLASS_WIDTH = neuron_pkg::CLASS_WIDTH,
  parameter int TIMEOUT_CYCLES = 128
) (
  input logic clk,
  input logic rst,
  neuron_layer_sequencer_if.slave bus
);
  import neuron_pkg::*;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic [CW-1:0] cnt;
  logic all_done, last;
  logic [CLASS_WIDTH-1:0] win_idx;
  logic signed [OUTPUT_WIDTH-1:0] win_score;
  assign all_done = &bus.neuron_done;
  argmax_scan #(
    .NUM_NEURONS(NUM_NEURONS),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .CLASS_WIDTH(CLASS_WIDTH)
  ) u_scan (
    .clk(clk),
    .rst(rst),
    .load(state == RUN && all_done),
    .step(state == SCAN),
    .vals(bus.neuron_out),
    .last(last),
    .win_idx(win_idx),
    .win_score(win_score)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.neuron_rst <= 1'b1;
      bus.busy <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_class <= '0;
      bus.result_score <= '0;
      bus.timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= RELEASE;
          cnt <= '0;
          bus.neuron_rst <= 1'b0;
          bus.busy <= 1'b1;
        end
        RELEASE: state <= RUN;
        RUN: begin
          cnt <= cnt + 1'b1;
          if (all_done) state <= SCAN;
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            bus.result_valid <= 1'b1;
            bus.timeout <= 1'b1;
            bus.result_class <= '0;
            bus.result_score <= '0;
          end
        end
        SCAN: if (last) begin
          state <= DONE;
          bus.result_valid <= 1'b1;
          bus.result_class <= win_idx;
          bus.result_score <= win_score;
        end
        DONE: begin
          state <= IDLE;
          bus.result_valid <= 1'b0;
          bus.timeout <= 1'b0;
          bus.busy <= 1'b0;
          bus.neuron_rst <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed and random classifications checked against a cycle-count/argmax reference model
module tb_neuron_layer_sequencer;
  import neuron_pkg::*;
  localparam int TMO = 128;
  localparam int ONE = 1 << 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int vals [NUM_NEURONS];
  int dly [NUM_NEURONS];
  neuron_layer_sequencer_if bus();
  neuron_layer_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, req);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, " neuron_rst"}, 64'(bus.neuron_rst), 64'd1);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " result_valid"}, 64'(bus.result_valid), 64'd0);
    chk({tag, " result_class"}, 64'(bus.result_class), 64'd0);
    chk({tag, " result_score"}, 64'(bus.result_score), 64'd0);
    chk({tag, " timeout"}, 64'(bus.timeout), 64'd0);
  endtask
  // n counts clock edges since the start edge; done driven at negedge n is seen at edge n
  task automatic do_run(input string tag, input int start_at, input int rst_at);
    int maxd, d, exp_n, best, pulses;
    logic exp_to;
    maxd = 0;
    for (int k = 0; k < NUM_NEURONS; k++) if (dly[k] > maxd) maxd = dly[k];
    d = maxd < 2 ? 2 : maxd;
    exp_to = d > TMO + 1;
    exp_n = exp_to ? TMO + 2 : d + NUM_NEURONS;
    best = 0;
    for (int k = 1; k < NUM_NEURONS; k++) if (vals[k] > vals[best]) best = k;
    for (int k = 0; k < NUM_NEURONS; k++) bus.neuron_out[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = out_t'(vals[k]);
    bus.neuron_done = '0;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= exp_n + 1; n++) begin
      if (n > 1) @(negedge clk);
      bus.start = (n == start_at);
      for (int k = 0; k < NUM_NEURONS; k++) bus.neuron_done[k] = (n >= dly[k]);
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.neuron_done = '0;
        check_reset({tag, " midrst"});
        return;
      end
      chk({tag, " valid"}, 64'(bus.result_valid), 64'(n == exp_n));
      chk({tag, " busy"}, 64'(bus.busy), 64'(n <= exp_n));
      chk({tag, " neuron_rst"}, 64'(bus.neuron_rst), 64'(n > exp_n));
      if (bus.result_valid) pulses++;
      if (n == exp_n) begin
        chk({tag, " class"}, 64'(bus.result_class), exp_to ? 64'd0 : 64'(best));
        chk({tag, " score"}, 64'(bus.result_score), exp_to ? 64'd0 : 64'(out_t'(vals[best])));
        chk({tag, " timeout"}, 64'(bus.timeout), 64'(exp_to));
      end
    end
    bus.start = 1'b0;
    bus.neuron_done = '0;
    chk({tag, " pulses"}, 64'(pulses), 64'd1);
  endtask
  task automatic set_dly(input int v);
    for (int k = 0; k < NUM_NEURONS; k++) dly[k] = v;
  endtask
  task automatic set_normal();
    for (int k = 0; k < NUM_NEURONS; k++) vals[k] = 0;
    vals[0] = -3 * ONE;
    vals[1] = ONE * 3 / 2;
    vals[2] = ONE * 29 / 4;
    vals[9] = -ONE;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.neuron_out = '0;
    bus.neuron_done = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle busy", 64'(bus.busy), 64'd0);
      chk("idle neuron_rst", 64'(bus.neuron_rst), 64'd1);
    end
    set_normal();
    set_dly(60);
    do_run("normal", 0, 0);
    chk("normal score const", 64'(bus.result_score), 64'(out_t'(26'h1D0000)));
    for (int k = 0; k < NUM_NEURONS; k++) vals[k] = -5 * ONE;
    vals[4] = -ONE / 2;
    vals[7] = -ONE / 2;
    for (int k = 0; k < NUM_NEURONS; k++) dly[k] = int'($urandom_range(2, 40));
    do_run("ties", 0, 0);
    chk("ties class const", 64'(bus.result_class), 64'd4);
    set_normal();
    set_dly(10);
    dly[9] = 1000;
    do_run("timeout", 0, 0);
    set_dly(129);
    do_run("edge129", 0, 0);
    set_dly(130);
    do_run("edge130", 0, 0);
    set_dly(30);
    do_run("start_in_run", 20, 0);
    do_run("start_in_valid", 40, 0);
    do_run("midscan_rst", 0, 33);
    set_normal();
    set_dly(60);
    do_run("after_rst", 0, 0);
    repeat (8) begin
      for (int k = 0; k < NUM_NEURONS; k++)
        vals[k] = (k > 0 && $urandom_range(0, 3) == 0) ? vals[int'($urandom_range(0, k - 1))]
                                                       : int'($urandom_range(0, 1 << 22)) - (1 << 21);
      for (int k = 0; k < NUM_NEURONS; k++) dly[k] = int'($urandom_range(1, 90));
      if ($urandom_range(0, 3) == 0) dly[int'($urandom_range(0, NUM_NEURONS - 1))] = int'($urandom_range(125, 140));
      do_run("random", 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_layer_sequencer.md
# neuron_layer_sequencer

Control FSM for the 10-neuron output layer of the MNIST classifier. It holds the neuron bank in reset while idle and releases it on `start`. It then waits for every neuron's `done`, or for a timeout. Finally it scans the neuron outputs one per cycle to produce the winning class and its score. It sits between the top-level image-load logic, which drives `start`, and the parallel `Neuron` instances, which share `neuron_rst`.

## Interface
Parameters:
- NUM_NEURONS, 10, number of neurons in the layer
- OUTPUT_WIDTH, 26, neuron output width, signed fixed point 8.18
- CLASS_WIDTH, 4, width of class index (≥ clog2(NUM_NEURONS))
- TIMEOUT_CYCLES, 128, maximum RUN cycles before abort

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one classification; sampled only in IDLE
- neuron_out  in  NUM_NEURONS*OUTPUT_WIDTH  concatenated neuron OUTs, neuron k at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- neuron_done  in  NUM_NEURONS  per-neuron done
- neuron_rst  out  1  registered reset to neuron bank
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse, result fields valid
- result_class  out  CLASS_WIDTH  argmax index
- result_score  out  OUTPUT_WIDTH  winning neuron value
- timeout  out  1  qualifies result_valid: run aborted

## Operation
- States: IDLE, RELEASE, RUN, SCAN, DONE.
- IDLE: `neuron_rst`=1, `busy`=0. When `start`=1, the FSM clears the cycle counter and goes to RELEASE.
- RELEASE: `neuron_rst`=0, one cycle. `neuron_done` is ignored here because it may be stale. Next state is RUN.
- RUN: `neuron_rst`=0. The counter increments each cycle.
  - `&neuron_done`=1 → SCAN. The scan index is 0, `best_score` is loaded with neuron 0, and `best_idx` is 0.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES-1 → DONE with the timeout flag set.
  - Completion takes priority over timeout in the same cycle.
- SCAN: index k runs from 1 to NUM_NEURONS-1, one per cycle.
  - Signed compare: if neuron_out[k] > best_score (strict), then best = (k, neuron_out[k]).
  - Ties keep the lower index.
  - After k=NUM_NEURONS-1 → DONE.
- SCAN relies on neurons holding OUT stable while `neuron_rst`=0 and done=1. `neuron_done` is not re-checked during SCAN.
- DONE: the FSM registers `result_class`/`result_score` from best, or 0/0 when timeout is set. It pulses `result_valid` and `timeout` for one cycle, then goes to IDLE.
- `result_class`/`result_score` hold until the next DONE or `rst`.
- A `start` outside IDLE is ignored; it is neither queued nor counted.
- `rst` in any state forces IDLE next cycle with all outputs at reset values. This includes mid-SCAN, where the partial best is discarded.

## Timing
- Reset values: `neuron_rst`=1, `busy`=0, `result_valid`=0, `result_class`=0, `result_score`=0, `timeout`=0.
- All outputs are registered; there are no combinational in→out paths.
- `start` sampled at edge t:
  - RELEASE during cycle t+1, so `neuron_rst` falls at t+1 and `busy` rises at t+1.
  - RUN from t+2.
- All-done first seen at edge d (in RUN):
  - SCAN occupies cycles d+1 … d+NUM_NEURONS-1.
  - DONE/`result_valid` at cycle d+NUM_NEURONS.
  - IDLE at d+NUM_NEURONS+1, where `neuron_rst` returns to 1.
- Timeout: `result_valid`=`timeout`=1 at cycle t+2+TIMEOUT_CYCLES.
- A back-to-back `start` asserted during the `result_valid` cycle is ignored. The earliest accepted `start` is the first IDLE cycle.

## Structure
- Shared package `neuron_pkg` holds:
  - the state enum
  - NUM_NEURONS, OUTPUT_WIDTH, CLASS_WIDTH constants, also used by the top level
  - the signed output type for 8.18 values
- One sub-module, `argmax_scan`: a sequential comparator with load/step inputs, the k-select mux and best registers.
- The FSM and counter stay in `neuron_layer_sequencer`.

## Test plan
- Reset then idle:
  - Outputs match their reset values.
  - `start`=0 for 20 cycles → `busy` stays 0 and `neuron_rst` stays 1.
- Normal run:
  - Stimulus: neuron_out = {−3.0, 1.5, 7.25, 0, …, −1}; model asserts all done 60 cycles after `neuron_rst` falls.
  - Response: `result_class`=2, `result_score`=7.25 (0x1D0000), `timeout`=0, `result_valid` exactly NUM_NEURONS cycles after done.
- Ties and negatives:
  - Stimulus: all outputs −5.0 except neurons 4 and 7 = −0.5.
  - Response: `result_class`=4.
- Timeout:
  - Stimulus: neuron 9 never asserts done.
  - Response: `result_valid`=`timeout`=1 at t+2+128, `result_class`=0, `result_score`=0; `neuron_rst` returns to 1.
- Ignored `start` and mid-op reset:
  - A `start` pulse during RUN → exactly one `result_valid`.
  - `rst` asserted on the third SCAN cycle → IDLE with reset outputs next cycle; a fresh `start` then completes correctly.
